// File: rtl/sel_pack_if.sv
// Chunk-in / word-out handshake bundle for sel_pack.
// slave is the assembler side, master is the producer/consumer side.
interface sel_pack_if #(
  parameter int W = 32,
  parameter int N = 4
);
  localparam int OUT_W = W / N;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic             i_in_vld;
  logic [OUT_W-1:0] i_in_dat;
  logic [IDX_W-1:0] i_in_idx;
  logic             o_in_rdy;
  logic             i_clr;
  logic             o_out_vld;
  logic [W-1:0]     o_out_dat;
  logic             i_out_rdy;
  logic             o_dup_err;
  logic             o_idx_err;

  modport slave (
    input  i_in_vld, i_in_dat, i_in_idx, i_clr, i_out_rdy,
    output o_in_rdy, o_out_vld, o_out_dat, o_dup_err, o_idx_err
  );

  modport master (
    output i_in_vld, i_in_dat, i_in_idx, i_clr, i_out_rdy,
    input  o_in_rdy, o_out_vld, o_out_dat, o_dup_err, o_idx_err
  );
endinterface

// File: rtl/sel_pack.sv
// Assembles a W-bit word from N indexed OUT_W-bit chunks arriving in any order;
// the completed word is handed downstream through a registered valid/ready slot.
module sel_pack #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  sel_pack_if.slave  bus
);
  localparam int OUT_W = W / N;

  generate
    if (N < 2 || W == 0 || (W % N) != 0) begin : g_bad_param
      $error("sel_pack: W must be a nonzero multiple of N, and N must be >= 2");
    end
  endgenerate

  typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

  state_t       r_state, w_state_nx;
  logic [W-1:0] r_bins, w_bins_nx;
  logic [N-1:0] r_mask, w_mask_nx, w_hit;
  logic [W-1:0] r_out_dat, w_out_dat_nx;
  logic         r_out_vld, w_out_vld_nx;
  logic         r_dup_err, w_dup_err_nx;
  logic         r_idx_err, w_idx_err_nx;
  logic [31:0]  w_idx_ext;
  logic         w_idx_ok, w_accept, w_slot_free;

  assign w_idx_ext   = 32'(bus.i_in_idx);
  assign w_accept    = bus.i_in_vld & (r_state == S_FILL);
  assign w_slot_free = ~r_out_vld | bus.i_out_rdy;

  // One-hot bin decode; an index >= N decodes to no bin at all.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < N; k++) begin
      w_hit[k] = (w_idx_ext == 32'(k));
    end
  end
  assign w_idx_ok = |w_hit;

  always_comb begin
    w_state_nx   = r_state;
    w_bins_nx    = r_bins;
    w_mask_nx    = r_mask;
    w_out_dat_nx = r_out_dat;
    w_out_vld_nx = r_out_vld & ~bus.i_out_rdy;
    w_dup_err_nx = 1'b0;
    w_idx_err_nx = 1'b0;
    case (r_state)
      S_FILL: begin
        if (bus.i_clr) begin
          w_mask_nx = '0;
        end else if (w_accept) begin
          if (!w_idx_ok) begin
            w_idx_err_nx = 1'b1;
          end else begin
            for (int k = 0; k < N; k++) begin
              if (w_hit[k]) w_bins_nx[OUT_W*k +: OUT_W] = bus.i_in_dat;
            end
            w_dup_err_nx = |(w_hit & r_mask);
            w_mask_nx    = r_mask | w_hit;
            if (&w_mask_nx) begin
              if (w_slot_free) begin
                w_out_dat_nx = w_bins_nx;
                w_out_vld_nx = 1'b1;
                w_mask_nx    = '0;
              end else begin
                w_state_nx = S_HOLD;
              end
            end
          end
        end
      end
      S_HOLD: begin
        if (w_slot_free) begin
          w_out_dat_nx = r_bins;
          w_out_vld_nx = 1'b1;
          w_mask_nx    = '0;
          w_state_nx   = S_FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= S_FILL;
      r_bins    <= '0;
      r_mask    <= '0;
      r_out_dat <= '0;
      r_out_vld <= 1'b0;
      r_dup_err <= 1'b0;
      r_idx_err <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_bins    <= w_bins_nx;
      r_mask    <= w_mask_nx;
      r_out_dat <= w_out_dat_nx;
      r_out_vld <= w_out_vld_nx;
      r_dup_err <= w_dup_err_nx;
      r_idx_err <= w_idx_err_nx;
    end
  end

  assign bus.o_in_rdy  = (r_state == S_FILL);
  assign bus.o_out_vld = r_out_vld;
  assign bus.o_out_dat = r_out_dat;
  assign bus.o_dup_err = r_dup_err;
  assign bus.o_idx_err = r_idx_err;
endmodule

// File: tb/tb_sel_pack.sv
// Directed bench for sel_pack: a 32/4 instance for the main paths and a 24/3
// instance for the out-of-range index case.
module tb_sel_pack;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sel_pack_if #(.W(32), .N(4)) ifa ();
  sel_pack_if #(.W(24), .N(3)) ifb ();

  sel_pack #(.W(32), .N(4)) u_dut_a (.clk(clk), .arst_n(arst_n), .bus(ifa.slave));
  sel_pack #(.W(24), .N(3)) u_dut_b (.clk(clk), .arst_n(arst_n), .bus(ifb.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [1:0] idx, input logic [7:0] dat);
    ifa.i_in_vld = 1'b1;
    ifa.i_in_idx = idx;
    ifa.i_in_dat = dat;
    tick();
    ifa.i_in_vld = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] idx, input logic [7:0] dat);
    ifb.i_in_vld = 1'b1;
    ifb.i_in_idx = idx;
    ifb.i_in_dat = dat;
    tick();
    ifb.i_in_vld = 1'b0;
  endtask

  initial begin
    ifa.i_in_vld = 1'b0; ifa.i_in_dat = '0; ifa.i_in_idx = '0; ifa.i_clr = 1'b0; ifa.i_out_rdy = 1'b1;
    ifb.i_in_vld = 1'b0; ifb.i_in_dat = '0; ifb.i_in_idx = '0; ifb.i_clr = 1'b0; ifb.i_out_rdy = 1'b1;

    // reset state
    #12;
    chk("rst_out_vld", 64'(ifa.o_out_vld), 64'd0);
    chk("rst_out_dat", 64'(ifa.o_out_dat), 64'd0);
    chk("rst_in_rdy",  64'(ifa.o_in_rdy),  64'd1);
    chk("rst_dup_err", 64'(ifa.o_dup_err), 64'd0);
    chk("rst_idx_err", 64'(ifa.o_idx_err), 64'd0);
    #3 arst_n = 1'b1;
    tick();

    // in-order word, downstream always ready
    send_a(2'd0, 8'h11); chk("seq0_vld", 64'(ifa.o_out_vld), 64'd0); chk("seq0_rdy", 64'(ifa.o_in_rdy), 64'd1);
    send_a(2'd1, 8'h22); chk("seq1_vld", 64'(ifa.o_out_vld), 64'd0); chk("seq1_rdy", 64'(ifa.o_in_rdy), 64'd1);
    send_a(2'd2, 8'h33); chk("seq2_vld", 64'(ifa.o_out_vld), 64'd0); chk("seq2_rdy", 64'(ifa.o_in_rdy), 64'd1);
    send_a(2'd3, 8'h44);
    chk("seq_vld", 64'(ifa.o_out_vld), 64'd1);
    chk("seq_dat", 64'(ifa.o_out_dat), 64'h44332211);
    chk("seq_rdy", 64'(ifa.o_in_rdy),  64'd1);
    tick();
    chk("seq_drained", 64'(ifa.o_out_vld), 64'd0);

    // out-of-order word
    send_a(2'd3, 8'h0D); send_a(2'd0, 8'h0A); send_a(2'd2, 8'h0C);
    chk("ooo_early_vld", 64'(ifa.o_out_vld), 64'd0);
    send_a(2'd1, 8'h0B);
    chk("ooo_vld", 64'(ifa.o_out_vld), 64'd1);
    chk("ooo_dat", 64'(ifa.o_out_dat), 64'h0D0C0B0A);
    tick();

    // duplicate bin overwrite
    send_a(2'd0, 8'h01); send_a(2'd1, 8'h02); send_a(2'd2, 8'h55);
    chk("dup_none", 64'(ifa.o_dup_err), 64'd0);
    send_a(2'd2, 8'h66);
    chk("dup_pulse", 64'(ifa.o_dup_err), 64'd1);
    chk("dup_no_word", 64'(ifa.o_out_vld), 64'd0);
    send_a(2'd3, 8'h04);
    chk("dup_cleared", 64'(ifa.o_dup_err), 64'd0);
    chk("dup_vld", 64'(ifa.o_out_vld), 64'd1);
    chk("dup_dat", 64'(ifa.o_out_dat), 64'h04660201);
    tick();

    // backpressure: word A parked, word B forces HOLD
    ifa.i_out_rdy = 1'b0;
    send_a(2'd0, 8'hA0); send_a(2'd1, 8'hA1); send_a(2'd2, 8'hA2); send_a(2'd3, 8'hA3);
    chk("bp_a_vld", 64'(ifa.o_out_vld), 64'd1);
    chk("bp_a_dat", 64'(ifa.o_out_dat), 64'hA3A2A1A0);
    send_a(2'd0, 8'hB0); send_a(2'd1, 8'hB1); send_a(2'd2, 8'hB2);
    chk("bp_fill_rdy", 64'(ifa.o_in_rdy), 64'd1);
    send_a(2'd3, 8'hB3);
    chk("hold_rdy", 64'(ifa.o_in_rdy), 64'd0);
    chk("hold_dat", 64'(ifa.o_out_dat), 64'hA3A2A1A0);
    tick();
    chk("hold_rdy2", 64'(ifa.o_in_rdy), 64'd0);
    chk("hold_dat2", 64'(ifa.o_out_dat), 64'hA3A2A1A0);
    chk("hold_vld2", 64'(ifa.o_out_vld), 64'd1);
    ifa.i_out_rdy = 1'b1;
    tick();
    chk("rel_b_vld", 64'(ifa.o_out_vld), 64'd1);
    chk("rel_b_dat", 64'(ifa.o_out_dat), 64'hB3B2B1B0);
    chk("rel_rdy",   64'(ifa.o_in_rdy),  64'd1);
    tick();
    chk("rel_drained", 64'(ifa.o_out_vld), 64'd0);

    // clear with a simultaneous chunk
    send_a(2'd0, 8'h11); send_a(2'd1, 8'h22);
    ifa.i_clr = 1'b1;
    send_a(2'd2, 8'h33);
    ifa.i_clr = 1'b0;
    chk("clr_dup", 64'(ifa.o_dup_err), 64'd0);
    chk("clr_vld", 64'(ifa.o_out_vld), 64'd0);
    send_a(2'd0, 8'hF0);
    chk("clr_fresh_dup", 64'(ifa.o_dup_err), 64'd0);
    send_a(2'd1, 8'hF1); send_a(2'd2, 8'hF2);
    chk("clr_no_early", 64'(ifa.o_out_vld), 64'd0);
    send_a(2'd3, 8'hF3);
    chk("clr_vld2", 64'(ifa.o_out_vld), 64'd1);
    chk("clr_dat",  64'(ifa.o_out_dat), 64'hF3F2F1F0);
    tick();
    chk("clr_one_word", 64'(ifa.o_out_vld), 64'd0);

    // async reset mid-word
    send_a(2'd0, 8'h91); send_a(2'd1, 8'h92);
    arst_n = 1'b0;
    #2;
    chk("rstw_vld", 64'(ifa.o_out_vld), 64'd0);
    chk("rstw_rdy", 64'(ifa.o_in_rdy),  64'd1);
    #2 arst_n = 1'b1;
    send_a(2'd0, 8'h05);
    chk("rstw_dup", 64'(ifa.o_dup_err), 64'd0);
    send_a(2'd1, 8'h06); send_a(2'd2, 8'h07);
    chk("rstw_no_early", 64'(ifa.o_out_vld), 64'd0);
    send_a(2'd3, 8'h08);
    chk("rstw_dat", 64'(ifa.o_out_dat), 64'h08070605);
    tick();

    // async reset during HOLD
    ifa.i_out_rdy = 1'b0;
    for (int k = 0; k < 4; k++) send_a(2'(k), 8'hC0 + 8'(k));
    for (int k = 0; k < 4; k++) send_a(2'(k), 8'hD0 + 8'(k));
    chk("rsth_pre_rdy", 64'(ifa.o_in_rdy), 64'd0);
    arst_n = 1'b0;
    #2;
    chk("rsth_vld", 64'(ifa.o_out_vld), 64'd0);
    chk("rsth_rdy", 64'(ifa.o_in_rdy),  64'd1);
    chk("rsth_dat", 64'(ifa.o_out_dat), 64'd0);
    #2 arst_n = 1'b1;
    tick();
    tick();
    chk("rsth_nothing", 64'(ifa.o_out_vld), 64'd0);
    ifa.i_out_rdy = 1'b1;
    send_a(2'd2, 8'h3C); send_a(2'd0, 8'h1A); send_a(2'd3, 8'h4D); send_a(2'd1, 8'h2B);
    chk("rsth_word_vld", 64'(ifa.o_out_vld), 64'd1);
    chk("rsth_word_dat", 64'(ifa.o_out_dat), 64'h4D3C2B1A);
    tick();

    // 24/3 instance: index 3 is out of range
    send_b(2'd0, 8'h01); send_b(2'd1, 8'h02);
    chk("b_idx_none", 64'(ifb.o_idx_err), 64'd0);
    send_b(2'd3, 8'hFF);
    chk("b_idx_pulse", 64'(ifb.o_idx_err), 64'd1);
    chk("b_idx_no_word", 64'(ifb.o_out_vld), 64'd0);
    chk("b_idx_rdy", 64'(ifb.o_in_rdy), 64'd1);
    send_b(2'd2, 8'h03);
    chk("b_idx_cleared", 64'(ifb.o_idx_err), 64'd0);
    chk("b_vld", 64'(ifb.o_out_vld), 64'd1);
    chk("b_dat", 64'(ifb.o_out_dat), 64'h030201);
    tick();
    chk("b_drained", 64'(ifb.o_out_vld), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
